// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the dense-layer MAC blocks.
// The MAC_LAYER_SAT_EN macro selects saturating narrowing in the users of saturate().
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ACT   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Address width that stays legal when a memory has a single entry.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in) + 1;
  endfunction

  function automatic wide_t relu(input wide_t v);
    if (v < 64'sd0) begin
      return {WIDE_W{1'b0}};
    end else begin
      return v;
    end
  endfunction

  function automatic wide_t saturate(input wide_t v, input int dw);
    wide_t lim;
    lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

  // Keep the low dw bits, then treat them as signed and clip negatives to zero.
  function automatic wide_t wrap_relu(input wide_t v, input int dw);
    wide_t mask;
    wide_t t;
    mask = (64'sd1 <<< dw) - 64'sd1;
    t    = v & mask;
    if (t[dw-1]) begin
      return {WIDE_W{1'b0}};
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/mac_layer_sched_if.sv
// Layer memory read ports and the valid/ready result stream of mac_layer_sched.
interface mac_layer_sched_if #(
  parameter int DW    = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 16
);
  import mac_pkg::*;

  localparam int XAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int NAW = addr_w(N_OUT);

  logic [XAW-1:0] x_addr;
  logic [DW-1:0]  x_data;
  logic [WAW-1:0] w_addr;
  logic [DW-1:0]  w_data;
  logic [NAW-1:0] b_addr;
  logic [DW-1:0]  b_data;
  logic           o_valid;
  logic           o_ready;
  logic [NAW-1:0] o_idx;
  logic [DW-1:0]  o_data;

  modport master (
    output x_addr, w_addr, b_addr, o_valid, o_idx, o_data,
    input  x_data, w_data, b_data, o_ready
  );

  modport slave (
    input  x_addr, w_addr, b_addr, o_valid, o_idx, o_data,
    output x_data, w_data, b_data, o_ready
  );
endinterface

// File: rtl/mac_acc_unit.sv
// Accumulates returning x*w products, adds the bias, rescales, applies ReLU and narrows.
// Narrowing saturates when MAC_LAYER_SAT_EN is defined, otherwise wraps.
module mac_acc_unit #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int N_IN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mac_en,
  input  logic          mac_first,
  input  logic          act_en,
  input  logic [DW-1:0] x_data,
  input  logic [DW-1:0] w_data,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] o_data
);
  import mac_pkg::*;

  localparam int AW = acc_w(DW, N_IN);

  logic                   vld_q, vld_d;
  logic                   first_q, first_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   bias_q, bias_d;
  logic [DW-1:0]          o_data_q, o_data_d;
  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]   prod_ext_s;
  logic signed [AW-1:0]   bias_ext_s;
  logic signed [AW-1:0]   sum_s;
  logic signed [AW-1:0]   shifted_s;
  wide_t                  wide_s;
  logic [DW-1:0]          narrow_s;

  // Memory data lags the address by one cycle, so the issue strobes are delayed to match.
  always_comb begin
    vld_d      = mac_en;
    first_d    = mac_first;
    prod_s     = $signed(x_data) * $signed(w_data);
    prod_ext_s = {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s};
    bias_ext_s = {{(AW-DW){bias_q[DW-1]}}, bias_q};
    sum_s      = acc_q + (bias_ext_s <<< FRAC);
    shifted_s  = sum_s >>> FRAC;
    wide_s     = {{(WIDE_W-AW){shifted_s[AW-1]}}, shifted_s};
`ifdef MAC_LAYER_SAT_EN
    narrow_s   = DW'(saturate(relu(wide_s), DW));
`else
    narrow_s   = DW'(wrap_relu(relu(wide_s), DW));
`endif
    if (vld_q) begin
      if (first_q) begin
        acc_d  = prod_ext_s;
        bias_d = $signed(b_data);
      end else begin
        acc_d  = acc_q + prod_ext_s;
        bias_d = bias_q;
      end
    end else begin
      acc_d  = acc_q;
      bias_d = bias_q;
    end
    if (act_en) begin
      o_data_d = narrow_s;
    end else begin
      o_data_d = o_data_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      acc_q    <= {AW{1'b0}};
      bias_q   <= {DW{1'b0}};
      o_data_q <= {DW{1'b0}};
    end else begin
      vld_q    <= vld_d;
      first_q  <= first_d;
      acc_q    <= acc_d;
      bias_q   <= bias_d;
      o_data_q <= o_data_d;
    end
  end

  assign o_data = o_data_q;

endmodule

// File: rtl/mac_layer_sched.sv
// Dense-layer scheduler: walks neurons and inputs over one shared MAC and streams ReLU results.
// Build option MAC_LAYER_SAT_EN: saturate results to DW bits instead of wrapping.
module mac_layer_sched #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int N_IN  = 16,
  parameter int N_OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  mac_layer_sched_if.master bus
);
  import mac_pkg::*;

  localparam int XAW = addr_w(N_IN);
  localparam int WAW = addr_w(N_IN * N_OUT);
  localparam int NAW = addr_w(N_OUT);
  localparam logic [XAW-1:0] J_LAST = XAW'(N_IN - 1);
  localparam logic [NAW-1:0] N_LAST = NAW'(N_OUT - 1);

  state_e         state_q, state_d;
  logic [XAW-1:0] j_q, j_d;
  logic [NAW-1:0] n_q, n_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           o_valid_q, o_valid_d;
  logic           mac_en;
  logic           mac_first;
  logic           act_en;
  logic [DW-1:0]  o_data_s;

  // Next-state, counters and addresses; w_addr steps by one so it always equals n*N_IN+j.
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    n_d      = n_q;
    w_addr_d = w_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          j_d      = {XAW{1'b0}};
          n_d      = {NAW{1'b0}};
          w_addr_d = {WAW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          j_d      = j_q + XAW'(1'b1);
          w_addr_d = w_addr_q + WAW'(1'b1);
        end
      end
      ST_DRAIN: state_d = ST_ACT;
      ST_ACT:   state_d = ST_OUT;
      ST_OUT: begin
        if (o_valid_q && bus.o_ready) begin
          if (n_q == N_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_FETCH;
            n_d      = n_q + NAW'(1'b1);
            j_d      = {XAW{1'b0}};
            w_addr_d = w_addr_q + WAW'(1'b1);
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d    = state_d inside {ST_FETCH, ST_DRAIN, ST_ACT, ST_OUT};
    done_d    = (state_d == ST_DONE);
    o_valid_d = (state_d == ST_OUT);
  end

  // Control registers; flag outputs follow the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      j_q       <= {XAW{1'b0}};
      n_q       <= {NAW{1'b0}};
      w_addr_q  <= {WAW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      n_q       <= n_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign mac_en    = (state_q == ST_FETCH);
  assign mac_first = mac_en && (j_q == {XAW{1'b0}});
  assign act_en    = (state_q == ST_ACT);

  mac_acc_unit #(
    .DW   (DW),
    .FRAC (FRAC),
    .N_IN (N_IN)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .act_en    (act_en),
    .x_data    (bus.x_data),
    .w_data    (bus.w_data),
    .b_data    (bus.b_data),
    .o_data    (o_data_s)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus.x_addr  = j_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.b_addr  = n_q;
  assign bus.o_idx   = n_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_s;

endmodule

// File: tb/tb_mac_layer_sched.sv
// Self-checking bench for mac_layer_sched (N_IN=4, N_OUT=2) with 1-cycle read memories
// and an arithmetic reference model of the neuron outputs.
module tb_mac_layer_sched;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] x_mem [N_IN];
  logic [15:0] w_mem [N_IN*N_OUT];
  logic [15:0] b_mem [N_OUT];

  mac_layer_sched_if #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  mac_layer_sched #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.x_data <= x_mem[bus.x_addr];
    bus.w_data <= w_mem[bus.w_addr];
    bus.b_data <= b_mem[bus.b_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Neuron value from plain integer arithmetic on the real-number meaning of the words.
  function automatic logic [15:0] ref_out(input int n);
    longint acc;
    longint s;
    acc = 0;
    for (int j = 0; j < N_IN; j++)
      acc += longint'($signed(x_mem[j])) * longint'($signed(w_mem[n*N_IN+j]));
    s = (acc + longint'($signed(b_mem[n])) * 256) >>> FRAC;
    if (s < 0) s = 0;
`ifdef MAC_LAYER_SAT_EN
    if (s > 32767) s = 32767;
`else
    s = s % 65536;
    if (s >= 32768) s = 0;
`endif
    return s[15:0];
  endfunction

  task automatic load_a();
    for (int j = 0; j < N_IN; j++) x_mem[j] = 16'((j + 1) * 256);
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 16'h0100;
    b_mem[0] = 16'h0000;
    b_mem[1] = 16'hEC00;
  endtask

  task automatic load_b();
    for (int j = 0; j < N_IN; j++) x_mem[j] = 16'h7F00;
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 16'h7F00;
    for (int n = 0; n < N_OUT; n++) b_mem[n] = 16'h0000;
  endtask

  task automatic load_rand();
    for (int j = 0; j < N_IN; j++) x_mem[j] = 16'($urandom);
    for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 16'($urandom);
    for (int n = 0; n < N_OUT; n++) b_mem[n] = 16'($urandom);
  endtask

  // One full layer pass with random backpressure; stall_cycles forces o_ready low on neuron 0.
  task automatic run_pass(input int stall_cycles, input bit extra_start);
    logic [15:0] exp_v [N_OUT];
    logic [31:0] snap;
    int  cyc, fetch_cyc, got, stall_left, idle_bad;
    bit  seen_valid, hs, finished;
    for (int n = 0; n < N_OUT; n++) exp_v[n] = ref_out(n);
    @(negedge clk); start = 1'b1; bus.o_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("first_addrs", {bus.x_addr, bus.w_addr, bus.b_addr}, 32'd0);
    cyc = 0; fetch_cyc = 0; got = 0; stall_left = stall_cycles;
    seen_valid = 1'b0; hs = 1'b0; finished = 1'b0; snap = 32'd0;
    while (!finished && cyc < 500) begin
      @(negedge clk);
      cyc++;
      start = extra_start && (cyc == 3);
      if (hs) begin
        hs = 1'b0;
        got++;
        seen_valid = 1'b0;
        check("valid_drop_after_hs", bus.o_valid, 1'b0);
        if (got == N_OUT) begin
          check("done_pulse", done, 1'b1);
          check("busy_low_at_done", busy, 1'b0);
          finished = 1'b1;
        end else begin
          fetch_cyc = cyc;
          check("next_neuron_addrs", {bus.x_addr, bus.w_addr, bus.b_addr},
                {2'd0, 3'(got * N_IN), 1'(got)});
          check("busy_between", busy, 1'b1);
        end
      end else if (bus.o_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check("valid_latency", cyc - fetch_cyc, N_IN + 2);
          check("o_idx", bus.o_idx, got);
          check("o_data", bus.o_data, exp_v[got]);
          snap = {bus.o_idx, bus.o_data, bus.x_addr, bus.w_addr, bus.b_addr};
        end else begin
          check("stall_stable", {bus.o_idx, bus.o_data, bus.x_addr, bus.w_addr, bus.b_addr}, snap);
        end
        if (stall_left > 0) begin
          stall_left--;
          bus.o_ready = 1'b0;
        end else begin
          bus.o_ready = ($urandom_range(0, 3) != 0);
        end
        hs = bus.o_ready;
      end else begin
        bus.o_ready = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    check("pass_finished", finished, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || bus.o_valid) idle_bad++;
    end
    check("idle_after_pass", idle_bad, 0);
  endtask

  initial begin
    int cnt;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    bus.o_ready = 1'b0;
    load_a();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_addrs", {bus.x_addr, bus.w_addr, bus.b_addr, bus.o_idx}, 32'd0);
    check("rst_o_data", bus.o_data, 16'h0000);
    rst = 1'b0;

    // x=1..4, w=1.0: neuron 0 = 10.0, neuron 1 pulled negative by its bias; 5-cycle stall.
    load_a();
    run_pass(5, 1'b0);

    // Large products: overflow of the output word, with a stray start while busy.
    load_b();
    run_pass(0, 1'b1);

    // Reset while neuron 1 is fetching, then a clean pass.
    load_a();
    bus.o_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!bus.o_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_test_valid", bus.o_valid, 1'b1);
    @(negedge clk);
    check("rst_test_in_n1", {busy, bus.b_addr, bus.x_addr}, {1'b1, 1'b1, 2'd0});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", bus.o_valid, 1'b0);
    check("midrst_state", {done, bus.x_addr, bus.w_addr, bus.b_addr, bus.o_data}, 32'd0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("midrst_no_done", bad, 0);
    run_pass(0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      load_rand();
      run_pass(int'($urandom_range(0, 3)), r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
